transmit_direction_select: RTL and testbench

TRANSMIT_DIRECTION_SELECT -- requirements
Module: transmit_direction_select

---
 rtl/transmit_direction_select_pkg.sv | 25 ++
 rtl/transmit_direction_select_if.sv | 41 ++++
 rtl/transmit_direction_select_tx_ack_timer.sv | 30 +++
 rtl/transmit_direction_select.sv | 146 ++++++++++++++
 tb/tb_transmit_direction_select.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/transmit_direction_select_pkg.sv
// Shared definitions for the transmit/receive direction selectors:
// direction encoding, data width and the handshake FSM state type.
package transmit_direction_select_pkg;

  localparam int TX_DATA_W = 16;

  localparam logic [1:0] DIR_E = 2'b00;
  localparam logic [1:0] DIR_S = 2'b01;
  localparam logic [1:0] DIR_W = 2'b10;
  localparam logic [1:0] DIR_N = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ACK,
    WAIT_REQ_LOW,
    WAIT_ACK_LOW,
    ABORT
  } tx_state_t;

  // Bit order of the returned vector is {N, W, S, E}.
  function automatic logic [3:0] dir_onehot(input logic [1:0] dir);
    return 4'b0001 << dir;
  endfunction

endpackage

// File: rtl/transmit_direction_select_if.sv
// Handshake bundle of the transmit direction selector: upstream port,
// four directional ports, direction control and status.
interface transmit_direction_select_if;
  import transmit_direction_select_pkg::*;

  logic                 TX_REQ;
  logic [TX_DATA_W-1:0] TX_DATA;
  logic                 TX_ACK;

  logic                 E_TX_REQ, S_TX_REQ, W_TX_REQ, N_TX_REQ;
  logic [TX_DATA_W-1:0] E_TX_DATA, S_TX_DATA, W_TX_DATA, N_TX_DATA;
  logic                 E_TX_ACK, S_TX_ACK, W_TX_ACK, N_TX_ACK;

  logic [1:0]           dir_i;
  logic                 dir_load;
  logic [1:0]           Send_Direction;
  logic                 busy;
  logic [15:0]          word_cnt;
  logic                 tx_timeout;

  modport slave (
    input  TX_REQ, TX_DATA,
    output TX_ACK,
    output E_TX_REQ, S_TX_REQ, W_TX_REQ, N_TX_REQ,
    output E_TX_DATA, S_TX_DATA, W_TX_DATA, N_TX_DATA,
    input  E_TX_ACK, S_TX_ACK, W_TX_ACK, N_TX_ACK,
    input  dir_i, dir_load,
    output Send_Direction, busy, word_cnt, tx_timeout
  );

  modport master (
    output TX_REQ, TX_DATA,
    input  TX_ACK,
    input  E_TX_REQ, S_TX_REQ, W_TX_REQ, N_TX_REQ,
    input  E_TX_DATA, S_TX_DATA, W_TX_DATA, N_TX_DATA,
    output E_TX_ACK, S_TX_ACK, W_TX_ACK, N_TX_ACK,
    output dir_i, dir_load,
    input  Send_Direction, busy, word_cnt, tx_timeout
  );

endinterface

// File: rtl/transmit_direction_select_tx_ack_timer.sv
// ACK-wait watchdog for the transmit selector; only built when
// TX_ACK_TIMEOUT_EN is defined.
`ifdef TX_ACK_TIMEOUT_EN
module transmit_direction_select_tx_ack_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic expired
);

  localparam int              CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // Counter reads 0 in the first waiting cycle, so expiry lands on cycle TIMEOUT_CYCLES.
  assign expired = run && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      cnt_q <= '0;
    end else if (!expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/transmit_direction_select.sv
// Routes upstream four-phase handshake words to one of four directional ports.
// Optional ACK-wait timeout with ABORT recovery: define TX_ACK_TIMEOUT_EN.
module transmit_direction_select
  import transmit_direction_select_pkg::*;
#(
  parameter logic [1:0] DEFAULT_DIR    = DIR_W,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  transmit_direction_select_if.slave    bus
);

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  tx_state_t            state_q, state_d;
  logic [1:0]           dir_q, dir_d;
  logic [TX_DATA_W-1:0] data_q, data_d;
  logic                 req_q, req_d;
  logic                 ack_q, ack_d;
  logic [15:0]          cnt_q, cnt_d;

  logic [3:0]           req_vec;
  logic                 sel_ack;
  logic                 ack_expired;

  // Only the ACK of the currently selected port can advance the FSM.
  assign sel_ack = |(dir_onehot(dir_q) &
                     {bus.N_TX_ACK, bus.W_TX_ACK, bus.S_TX_ACK, bus.E_TX_ACK});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= DEFAULT_DIR;
      data_q  <= '0;
      req_q   <= 1'b0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    data_d  = data_q;
    req_d   = req_q;
    ack_d   = ack_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // A direction load wins; a simultaneous request is taken next cycle.
        if (bus.dir_load) begin
          dir_d = bus.dir_i;
          cnt_d = '0;
        end else if (bus.TX_REQ) begin
          data_d  = bus.TX_DATA;
          req_d   = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sel_ack) begin
          ack_d   = 1'b1;
          state_d = WAIT_REQ_LOW;
        end else if (ack_expired) begin
          req_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = ABORT;
        end
      end
      WAIT_REQ_LOW: begin
        if (!bus.TX_REQ) begin
          req_d   = 1'b0;
          state_d = WAIT_ACK_LOW;
        end
      end
      WAIT_ACK_LOW: begin
        if (!sel_ack) begin
          ack_d   = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      ABORT: begin
        if (!bus.TX_REQ) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef TX_ACK_TIMEOUT_EN
  logic tmo_q;

  transmit_direction_select_tx_ack_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tx_ack_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (state_q == WAIT_ACK),
    .expired (ack_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= (state_q == WAIT_ACK) && !sel_ack && ack_expired;
    end
  end

  assign bus.tx_timeout = tmo_q;
`else
  assign ack_expired    = 1'b0;
  assign bus.tx_timeout = 1'b0;
`endif

  assign req_vec = req_q ? dir_onehot(dir_q) : 4'b0000;

  assign bus.E_TX_REQ  = req_vec[DIR_E];
  assign bus.S_TX_REQ  = req_vec[DIR_S];
  assign bus.W_TX_REQ  = req_vec[DIR_W];
  assign bus.N_TX_REQ  = req_vec[DIR_N];

  assign bus.E_TX_DATA = data_q;
  assign bus.S_TX_DATA = data_q;
  assign bus.W_TX_DATA = data_q;
  assign bus.N_TX_DATA = data_q;

  assign bus.TX_ACK         = ack_q;
  assign bus.Send_Direction = dir_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.word_cnt       = cnt_q;

endmodule

// File: tb/tb_transmit_direction_select.sv
// Scoreboard bench for transmit_direction_select: stimulus pushes expected
// {direction, data} words, a monitor pops them on each directional REQ rise.
module tb_transmit_direction_select;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  transmit_direction_select_if bus ();

  transmit_direction_select #(
    .DEFAULT_DIR    (2'b10),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [17:0] exp_q[$];
  logic [1:0]  exp_dir;
  logic [15:0] exp_cnt;

  logic [3:0]  ack_v  = 4'b0;
  logic [3:0]  stray  = 4'b0;
  logic        resp_en = 1'b1;
  int          ack_dly = 2;
  int          dly_cnt[4];

  assign bus.E_TX_ACK = ack_v[0] | stray[0];
  assign bus.S_TX_ACK = ack_v[1] | stray[1];
  assign bus.W_TX_ACK = ack_v[2] | stray[2];
  assign bus.N_TX_ACK = ack_v[3] | stray[3];

  function automatic logic [3:0] reqv();
    return {bus.N_TX_REQ, bus.W_TX_REQ, bus.S_TX_REQ, bus.E_TX_REQ};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, input string name);
    int n = 0;
    while (bus.TX_ACK !== lvl && n < 50) begin
      tick();
      n++;
    end
    chk(name, bus.TX_ACK, lvl);
  endtask

  // Downstream agent: echo ACK ack_dly cycles after REQ rises, drop it after REQ falls.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
        if (reqv()[d] !== 1'b1) begin
          ack_v[d]   = 1'b0;
          dly_cnt[d] = 0;
        end else if (resp_en && !ack_v[d]) begin
          if (dly_cnt[d] + 1 >= ack_dly) ack_v[d] = 1'b1;
          else dly_cnt[d]++;
        end
      end
    end
  end

  // Monitor / scoreboard.
  logic [3:0]  prev_req = 4'b0;
  logic [15:0] cur_data;
  logic [1:0]  cur_dir;
  logic        inflight = 1'b0;

  always @(negedge clk) begin
    logic [3:0]  rv, av, rise;
    logic [17:0] item;
    rv = reqv();
    av = {bus.N_TX_ACK, bus.W_TX_ACK, bus.S_TX_ACK, bus.E_TX_ACK};
    if (rst_n !== 1'b1) begin
      inflight = 1'b0;
      prev_req = 4'b0;
    end else begin
      if (rv != prev_req)
        chk("req_onehot", 64'($countones(rv) <= 1), 64'd1);
      rise = rv & ~prev_req;
      if (rise != 4'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_req", rise, 64'd0);
        end else begin
          item = exp_q.pop_front();
          chk("req_port", rise, 64'(4'b0001 << item[17:16]));
          chk("req_data", {bus.E_TX_DATA, bus.S_TX_DATA, bus.W_TX_DATA, bus.N_TX_DATA},
              {4{item[15:0]}});
          cur_dir  = item[17:16];
          cur_data = item[15:0];
          inflight = 1'b1;
        end
      end else if (inflight) begin
        chk("data_stable", {bus.E_TX_DATA, bus.S_TX_DATA, bus.W_TX_DATA, bus.N_TX_DATA},
            {4{cur_data}});
        if (!rv[cur_dir] && !av[cur_dir]) inflight = 1'b0;
      end
      prev_req = rv;
    end
  end

  // mode 0: plain word; 1: dir_load pulse during WAIT_ACK; 2: dir_load with TX_REQ.
  task automatic send_word(input logic [15:0] d, input int mode, input logic [1:0] ld_dir);
    bus.TX_DATA = d;
    if (mode == 2) begin
      exp_dir = ld_dir;
      exp_cnt = 16'd0;
      exp_q.push_back({exp_dir, d});
      bus.TX_REQ   = 1'b1;
      bus.dir_i    = ld_dir;
      bus.dir_load = 1'b1;
      tick();
      bus.dir_load = 1'b0;
      chk("req_held_on_load", reqv(), 64'd0);
      chk("dir_loaded", bus.Send_Direction, ld_dir);
      chk("cnt_cleared", bus.word_cnt, 64'd0);
    end else begin
      exp_q.push_back({exp_dir, d});
      bus.TX_REQ = 1'b1;
    end
    tick();
    chk("req_sel", reqv(), 64'(4'b0001 << exp_dir));
    chk("busy_hi", bus.busy, 64'd1);
    if (mode == 1) begin
      bus.dir_i    = ld_dir;
      bus.dir_load = 1'b1;
    end
    tick();
    bus.dir_load = 1'b0;
    chk("ack_early", bus.TX_ACK, 64'd0);
    wait_ack(1'b1, "ack_rise");
    bus.TX_REQ = 1'b0;
    wait_ack(1'b0, "ack_fall");
    exp_cnt++;
    chk("word_cnt", bus.word_cnt, exp_cnt);
  endtask

  task automatic load_dir(input logic [1:0] d);
    bus.dir_i    = d;
    bus.dir_load = 1'b1;
    tick();
    bus.dir_load = 1'b0;
    exp_dir = d;
    exp_cnt = 16'd0;
    chk("load_dir", bus.Send_Direction, d);
    chk("load_clr_cnt", bus.word_cnt, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.TX_REQ   = 1'b0;
    bus.TX_DATA  = 16'h0;
    bus.dir_i    = 2'b00;
    bus.dir_load = 1'b0;
    rst_n        = 1'b0;
    exp_dir      = 2'b10;
    exp_cnt      = 16'd0;
    repeat (3) tick();

    chk("rst_dir", bus.Send_Direction, 64'd2);
    chk("rst_busy", bus.busy, 64'd0);
    chk("rst_tx_ack", bus.TX_ACK, 64'd0);
    chk("rst_reqs", reqv(), 64'd0);
    chk("rst_cnt", bus.word_cnt, 64'd0);
    chk("rst_tmo", bus.tx_timeout, 64'd0);
    chk("rst_data", bus.W_TX_DATA, 64'd0);
    rst_n = 1'b1;
    tick();

    send_word(16'hA5A5, 0, 2'b00);

    stray = 4'b1011;
    send_word(16'h1234, 0, 2'b00);
    stray = 4'b0000;

    load_dir(2'b00);
    send_word(16'h0001, 0, 2'b00);
    send_word(16'hBEEF, 0, 2'b00);
    send_word(16'hFFFF, 0, 2'b00);
    chk("dir_after_3", bus.Send_Direction, 64'd0);

    send_word(16'hC3C3, 1, 2'b11);
    chk("dir_load_ignored", bus.Send_Direction, 64'd0);

    send_word(16'h5A5A, 2, 2'b01);
    send_word(16'h0F0F, 0, 2'b00);

    // Reset while parked in WAIT_REQ_LOW.
    exp_q.push_back({exp_dir, 16'h7777});
    bus.TX_DATA = 16'h7777;
    bus.TX_REQ  = 1'b1;
    tick();
    chk("req_sel_rst", reqv(), 64'(4'b0001 << exp_dir));
    wait_ack(1'b1, "ack_rise_rst");
    rst_n = 1'b0;
    tick();
    chk("midrst_reqs", reqv(), 64'd0);
    chk("midrst_ack", bus.TX_ACK, 64'd0);
    chk("midrst_busy", bus.busy, 64'd0);
    chk("midrst_cnt", bus.word_cnt, 64'd0);
    chk("midrst_dir", bus.Send_Direction, 64'd2);
    bus.TX_REQ = 1'b0;
    rst_n      = 1'b1;
    exp_dir    = 2'b10;
    exp_cnt    = 16'd0;
    repeat (2) tick();

    send_word(16'h1357, 0, 2'b00);

`ifdef TX_ACK_TIMEOUT_EN
    begin
      int hi = 0;
      resp_en = 1'b0;
      exp_q.push_back({exp_dir, 16'hDEAD});
      bus.TX_DATA = 16'hDEAD;
      bus.TX_REQ  = 1'b1;
      tick();
      while (reqv()[exp_dir] === 1'b1 && hi < 100) begin
        hi++;
        tick();
      end
      chk("tmo_req_cycles", 64'(hi), 64'd16);
      chk("tmo_pulse", bus.tx_timeout, 64'd1);
      chk("abort_ack", bus.TX_ACK, 64'd1);
      tick();
      chk("tmo_pulse_end", bus.tx_timeout, 64'd0);
      chk("abort_ack_hold", bus.TX_ACK, 64'd1);
      bus.TX_REQ = 1'b0;
      tick();
      chk("abort_ack_low", bus.TX_ACK, 64'd0);
      chk("abort_idle", bus.busy, 64'd0);
      chk("abort_cnt", bus.word_cnt, exp_cnt);
      resp_en = 1'b1;
    end
`endif

    repeat (3) tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
